fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the vectorial ASIP, directly upstream of `decoderStage`. It owns the program counter and reads 16-bit instructions from the combinational instruction ROM. It holds them in the IF/ID register that drives the decoder's `instruction` input, and resolves `jmp`/`je`/`jne` using the decoder's `PcWriteEn` and `Immediate` outputs plus the Z flag.

## Interface
- `PC_W`, default 8: PC width; it matches the 8-bit `Immediate` absolute branch target.
- `INSTR_W`, default 16: instruction width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hazard hold; freezes the PC, the IF/ID register and the state.
- `pc_write_en`  in  3: from decoder `PcWriteEn`; 3'b100 = jmp, 3'b010 = je, 3'b001 = jne.
- `branch_target`  in  PC_W: from decoder `Immediate`.
- `zero_flag`  in  1: Z bit of the NZ flags register.
- `imem_addr`  out  PC_W: ROM address; equals `pc_q`.
- `imem_rdata`  in  INSTR_W: ROM data, combinational from `imem_addr`.
- `instruction`  out  INSTR_W: IF/ID instruction register, drives the decoder.
- `instr_valid`  out  1: 0 marks a bubble; downstream write enables are gated with it.
- `instr_pc`  out  PC_W: address of the instruction currently held in IF/ID.
- `halted`  out  1: high in state HALT.

## Operation
- FSM states:
  - BOOT: one cycle after reset.
  - RUN
  - HALT
- Transitions:
  - `rst` sends the FSM to BOOT from any state, including mid-branch or mid-stall.
  - BOOT goes to RUN unconditionally.
  - RUN goes to HALT when a halt opcode (`imem_rdata[15:12]==4'hE`) is captured, provided no branch is taken that cycle.
  - HALT is left only via `rst`.
- Branch taken when any of these holds (priority jmp > je > jne if several bits are set):
  - `pc_write_en[2]`
  - `pc_write_en[1] && zero_flag`
  - `pc_write_en[0] && !zero_flag`
- In RUN, no stall:
  - Taken branch: `pc_q` <= `branch_target`; IF/ID <= bubble (instruction 16'h0000, valid 0). The wrong-path word on `imem_rdata` is discarded, even if it is a halt opcode.
  - Otherwise: IF/ID <= {`imem_rdata`, valid 1, `pc_q`}; `pc_q` <= `pc_q`+1, wrapping from 8'hFF to 8'h00.
- Stall, in any state: all registers hold and `pc_write_en` is ignored. The branch is re-evaluated when `stall` drops because the decoder still sees the same instruction.
- HALT:
  - Halt instruction: presented with valid=1 for exactly one cycle.
  - Afterwards: valid=0, instruction and `instr_pc` are held, and `pc_q` is frozen at halt address + 1.
  - `pc_write_en` is ignored.
- BOOT: `pc_q` is 0, valid is 0, nothing is captured; the word at address 0 is captured on the first RUN edge.

## Timing
- Reset values:
  - `pc_q` = 0, so `imem_addr` = 0
  - `instruction` = 16'h0000
  - `instr_valid` = 0
  - `instr_pc` = 0
  - `halted` = 0
  - state = BOOT
- Fetch latency: the word at `imem_addr` appears on `instruction` one cycle later.
- Sequential throughput: one instruction per cycle.
- Taken-branch penalty: exactly one bubble cycle. The target instruction is valid on the second edge after the branch is seen in ID.
- `pc_write_en`, `branch_target` and `zero_flag` are sampled on the same edge as the IF/ID update; there is no registered path.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `fetch_count` (16 bit, +1 per cycle with valid captured) and `flush_count` (16 bit, +1 per taken branch).
  - Both reset to 0, saturate at 16'hFFFF, and hold during stall.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

## Structure
- `asip_pkg` holds:
  - `OP_HALT` = 4'hE
  - `PCW_JMP`/`PCW_JE`/`PCW_JNE` one-hot masks
  - `BUBBLE_INSTR` = 16'h0000
  - fetch state enum `fetch_state_t`
- Sub-module `branch_unit` (combinational): takes `pc_write_en` and `zero_flag`; produces `take_branch`. The decoder-side tests reuse its encoding.

## Test plan
- ROM 0..3 = 0x0612, 0x3260, 0x1370, 0x2190; release `rst`:
  - BOOT cycle: valid=0.
  - Next four cycles: `instruction` = those words with `instr_pc` 0..3.
- `pc_write_en`=3'b100, target=0x15 while `instr_pc`=2:
  - next cycle: bubble (valid=0);
  - following cycle: `instr_pc`=0x15, word from ROM[0x15].
- je/jne, target 0x10:
  - `pc_write_en`=3'b010 with `zero_flag`=0: not taken, PC increments.
  - `pc_write_en`=3'b001 with `zero_flag`=0: jumps to 0x10.
- `stall` held 3 cycles while jmp sits in ID: PC, `instruction` and `instr_pc` are unchanged; the branch is taken on the first cycle after `stall` drops.
- ROM[5]=0xE000: valid for one cycle with `instr_pc`=5, then `halted`=1, valid=0, `imem_addr` stuck at 6. Same case with jmp to 0x20 in ID while 0xE000 is fetched: no halt, jumps.
- PC wrap: ROM[0xFF] non-branch, so next `instr_pc`=0x00. Assert `rst` mid-branch: all outputs return to reset values the next cycle.
- With `FETCH_PERF_CNT_EN`: 10 sequential fetches plus 2 taken jumps give `fetch_count`=10, `flush_count`=2.

Source files
------------

// File: rtl/asip_pkg.sv
// asip_pkg: shared constants and types for the ASIP front end.
// Contents: halt opcode, PcWriteEn one-hot masks, bubble word,
// and the fetch FSM state encoding (fetch_state_t).
package asip_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned PCW_W    = 3;

  localparam logic [OPCODE_W-1:0] OP_HALT = 4'hE;

  localparam logic [PCW_W-1:0] PCW_JMP = 3'b100;
  localparam logic [PCW_W-1:0] PCW_JE  = 3'b010;
  localparam logic [PCW_W-1:0] PCW_JNE = 3'b001;

  localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

  // Fixed state codes kept as plain constants for legacy tools.
  localparam logic [1:0] FS_BOOT = 2'd0;
  localparam logic [1:0] FS_RUN  = 2'd1;
  localparam logic [1:0] FS_HALT = 2'd2;

  typedef enum logic [1:0] {
    ST_BOOT = FS_BOOT,
    ST_RUN  = FS_RUN,
    ST_HALT = FS_HALT
  } fetch_state_t;

endpackage

// File: rtl/branch_unit.sv
// branch_unit: combinational branch resolution for jmp/je/jne.
// Ports:
//   pc_write_en  in  3  decoder PcWriteEn (jmp/je/jne one-hot masks)
//   zero_flag    in  1  Z flag
//   take_branch  out 1  branch is taken this cycle
module branch_unit
  import asip_pkg::*;
(
  input  logic [PCW_W-1:0] pc_write_en,
  input  logic             zero_flag,
  output logic             take_branch
);

  logic jmp_hit;
  logic je_hit;
  logic jne_hit;

  // All variants share one target, so any satisfied condition takes the branch.
  always_comb begin
    jmp_hit     = |(pc_write_en & PCW_JMP);
    je_hit      = (|(pc_write_en & PCW_JE)) && zero_flag;
    jne_hit     = (|(pc_write_en & PCW_JNE)) && !zero_flag;
    take_branch = jmp_hit || je_hit || jne_hit;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the vectorial ASIP. Owns the PC, reads
// the combinational ROM and fills the IF/ID register feeding the decoder.
// Ports:
//   clk, rst (sync, active-high), stall (freezes everything)
//   pc_write_en, branch_target, zero_flag : branch resolution inputs from ID
//   imem_addr / imem_rdata                : combinational ROM interface
//   instruction, instr_valid, instr_pc    : IF/ID register
//   halted                                : FSM is in HALT
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / flush_count (16-bit,
// saturating).
module fetch_stage
  import asip_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [2:0]         pc_write_en,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               zero_flag,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    instr_pc,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        flush_count
`endif
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic               halted_q, halted_d;
  logic               take_branch;
  logic               capture;
  logic               flush;

  branch_unit u_branch_unit (
    .pc_write_en (pc_write_en),
    .zero_flag   (zero_flag),
    .take_branch (take_branch)
  );

  // Next-state and IF/ID update; stall leaves every *_d at its *_q value.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    ipc_d   = ipc_q;
    capture = 1'b0;
    flush   = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (take_branch) begin
            // Wrong-path word is dropped, even a halt opcode.
            pc_d    = branch_target;
            instr_d = INSTR_W'(BUBBLE_INSTR);
            valid_d = 1'b0;
            flush   = 1'b1;
          end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            ipc_d   = pc_q;
            pc_d    = pc_q + PC_W'(1);
            capture = 1'b1;
            if (imem_rdata[INSTR_W-1 -: OPCODE_W] == OP_HALT) state_d = ST_HALT;
          end
        end
        ST_HALT: valid_d = 1'b0;
        default: state_d = ST_BOOT;
      endcase
    end
    halted_d = (state_d == ST_HALT);
  end

  // State and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      ipc_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      ipc_q    <= ipc_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign instr_pc    = ipc_q;
  assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] fetch_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating event counters; capture/flush are already stall-gated.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      if (capture && (fetch_q != {CNT_W{1'b1}})) fetch_q <= fetch_q + CNT_W'(1);
      if (flush && (flush_q != {CNT_W{1'b1}}))   flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign fetch_count = fetch_q;
  assign flush_count = flush_q;
`else
  logic unused_cnt;
  assign unused_cnt = capture ^ flush;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage with an abstract model
// of the fetch pipeline, directed scenarios and a randomized phase.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  pc_write_en = 3'b000;
  logic [7:0]  branch_target = 8'h00;
  logic        zero_flag = 1'b0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  logic [15:0] rom [256];
  assign imem_rdata = rom[imem_addr];

  fetch_stage #(.PC_W(8), .INSTR_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_write_en   (pc_write_en),
    .branch_target (branch_target),
    .zero_flag     (zero_flag),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .flush_count   (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Abstract model: "booting", "halted", program counter, IF/ID contents.
  bit          m_boot;
  bit          m_halt;
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  logic        m_valid;
  logic [7:0]  m_ipc;
  int          m_fetch;
  int          m_flush;

  task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit taken;
    if (rst) begin
      m_boot = 1'b1; m_halt = 1'b0; m_pc = 8'h00; m_instr = 16'h0000;
      m_valid = 1'b0; m_ipc = 8'h00; m_fetch = 0; m_flush = 0;
    end else if (!stall) begin
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_halt) begin
        m_valid = 1'b0;
      end else begin
        taken = pc_write_en[2] || (pc_write_en[1] && zero_flag) ||
                (pc_write_en[0] && !zero_flag);
        if (taken) begin
          m_pc = branch_target; m_instr = 16'h0000; m_valid = 1'b0;
          if (m_flush < 65535) m_flush++;
        end else begin
          m_instr = rom[m_pc]; m_valid = 1'b1; m_ipc = m_pc;
          m_pc = 8'((int'(m_pc) + 1) % 256);
          if (m_fetch < 65535) m_fetch++;
          if (m_instr[15:12] == 4'hE) m_halt = 1'b1;
        end
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      expect_val("model_instruction", 32'(instruction), 32'(m_instr));
      expect_val("model_valid", 32'(instr_valid), 32'(m_valid));
      expect_val("model_instr_pc", 32'(instr_pc), 32'(m_ipc));
      expect_val("model_imem_addr", 32'(imem_addr), 32'(m_pc));
      expect_val("model_halted", 32'(halted), 32'(m_halt));
`ifdef FETCH_PERF_CNT_EN
      expect_val("model_fetch_count", 32'(fetch_count), 32'(m_fetch));
      expect_val("model_flush_count", 32'(flush_count), 32'(m_flush));
`endif
    end
  end

  task automatic step(input logic r, input logic s, input logic [2:0] p,
                      input logic [7:0] t, input logic zf);
    rst = r; stall = s; pc_write_en = p; branch_target = t; zero_flag = zf;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b000, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 3'b000, 8'h00, 1'b0);
    step(1'b0, 1'b0, 3'b000, 8'h00, 1'b0);
  endtask

  task automatic expect_reset_values(input string tag);
    expect_val({tag, "_instruction"}, 32'(instruction), 32'h0000);
    expect_val({tag, "_valid"}, 32'(instr_valid), 32'h0);
    expect_val({tag, "_instr_pc"}, 32'(instr_pc), 32'h00);
    expect_val({tag, "_imem_addr"}, 32'(imem_addr), 32'h00);
    expect_val({tag, "_halted"}, 32'(halted), 32'h0);
  endtask

  logic [15:0] first_words [4];

  initial begin
    first_words = '{16'h0612, 16'h3260, 16'h1370, 16'h2190};
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
    for (int i = 0; i < 4; i++) rom[i] = first_words[i];
    rom[5] = 16'hE000;

    // Reset and the BOOT cycle.
    step(1'b1, 1'b0, 3'b000, 8'h00, 1'b0);
    chk_on = 1'b1;
    expect_reset_values("reset");
    step(1'b0, 1'b0, 3'b000, 8'h00, 1'b0);
    expect_val("boot_valid", 32'(instr_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      expect_val("seq_instruction", 32'(instruction), 32'(first_words[k]));
      expect_val("seq_instr_pc", 32'(instr_pc), 32'(k));
    end

    // jmp with instr_pc=2 in ID.
    do_reset();
    idle(3);
    expect_val("pre_jmp_pc", 32'(instr_pc), 32'h02);
    step(1'b0, 1'b0, 3'b100, 8'h15, 1'b0);
    expect_val("jmp_bubble", 32'(instr_valid), 32'h0);
    idle(1);
    expect_val("jmp_target_pc", 32'(instr_pc), 32'h15);
    expect_val("jmp_target_word", 32'(instruction), 32'h1015);

    // je not taken, jne taken.
    step(1'b0, 1'b0, 3'b010, 8'h10, 1'b0);
    expect_val("je_nt_valid", 32'(instr_valid), 32'h1);
    expect_val("je_nt_pc", 32'(instr_pc), 32'h16);
    step(1'b0, 1'b0, 3'b001, 8'h10, 1'b0);
    expect_val("jne_bubble", 32'(instr_valid), 32'h0);
    idle(1);
    expect_val("jne_target_pc", 32'(instr_pc), 32'h10);

    // Stall for 3 cycles with jmp in ID.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'b100, 8'h40, 1'b0);
      expect_val("stall_instr_pc", 32'(instr_pc), 32'h10);
      expect_val("stall_instruction", 32'(instruction), 32'h1010);
      expect_val("stall_imem_addr", 32'(imem_addr), 32'h11);
    end
    step(1'b0, 1'b0, 3'b100, 8'h40, 1'b0);
    expect_val("post_stall_bubble", 32'(instr_valid), 32'h0);
    expect_val("post_stall_addr", 32'(imem_addr), 32'h40);
    idle(1);
    expect_val("post_stall_target", 32'(instr_pc), 32'h40);

    // Halt at address 5.
    do_reset();
    idle(6);
    expect_val("halt_word", 32'(instruction), 32'hE000);
    expect_val("halt_word_valid", 32'(instr_valid), 32'h1);
    expect_val("halt_word_pc", 32'(instr_pc), 32'h05);
    idle(1);
    expect_val("halted_flag", 32'(halted), 32'h1);
    expect_val("halted_valid", 32'(instr_valid), 32'h0);
    expect_val("halted_addr", 32'(imem_addr), 32'h06);
    expect_val("halted_instruction", 32'(instruction), 32'hE000);
    step(1'b0, 1'b0, 3'b100, 8'h30, 1'b0);
    expect_val("halted_ignores_jmp", 32'(imem_addr), 32'h06);

    // Halt word on the wrong path of a jmp.
    do_reset();
    idle(5);
    expect_val("pre_halt_jmp_addr", 32'(imem_addr), 32'h05);
    step(1'b0, 1'b0, 3'b100, 8'h20, 1'b0);
    expect_val("halt_discard_halted", 32'(halted), 32'h0);
    expect_val("halt_discard_valid", 32'(instr_valid), 32'h0);
    idle(1);
    expect_val("halt_discard_target", 32'(instr_pc), 32'h20);

    // PC wrap, then reset in the middle of a branch.
    step(1'b0, 1'b0, 3'b100, 8'hFF, 1'b0);
    idle(1);
    expect_val("wrap_ff", 32'(instr_pc), 32'hFF);
    idle(1);
    expect_val("wrap_00", 32'(instr_pc), 32'h00);
    expect_val("wrap_word", 32'(instruction), 32'h0612);
    step(1'b1, 1'b0, 3'b100, 8'h33, 1'b0);
    expect_reset_values("mid_branch_reset");

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    step(1'b0, 1'b0, 3'b100, 8'h80, 1'b0);
    idle(10);
    step(1'b0, 1'b0, 3'b100, 8'h90, 1'b0);
    expect_val("perf_fetch", 32'(fetch_count), 32'd10);
    expect_val("perf_flush", 32'(flush_count), 32'd2);
`endif

    // Randomized phase: random ROM image, branches, stalls and resets.
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'($urandom);
      if (rom[i][15:12] == 4'hE && ($urandom % 4) != 0) rom[i][15:12] = 4'h1;
    end
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic       r;
      logic       s;
      logic [2:0] p;
      r = (($urandom % 300) == 0) || (m_halt && (($urandom % 10) == 0));
      s = (($urandom % 4) == 0);
      p = (($urandom % 3) == 0) ? 3'($urandom) : 3'b000;
      step(r, s, p, 8'($urandom), 1'($urandom));
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
